// File: rtl/demux4_router.sv
// ============================================================================
// Module   : demux4_router
// Purpose  : 1-to-4 registered demultiplexer with a one-entry valid/ready
//            holding register per output channel.
// Options  : define DEMUX4_COUNT_EN to add per-channel 8-bit accept counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux4_router #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       s,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic             v0,
   output logic             v1,
   output logic             v2,
   output logic             v3,
   input  logic             r0,
   input  logic             r1,
   input  logic             r2,
   input  logic             r3
`ifdef DEMUX4_COUNT_EN
   ,
   output logic [7:0]       cnt0,
   output logic [7:0]       cnt1,
   output logic [7:0]       cnt2,
   output logic [7:0]       cnt3
`endif
);

   localparam int c_nch = 4;

   logic [c_nch-1:0]             w_rdy;
   logic [c_nch-1:0]             w_full;
   logic [c_nch-1:0][WIDTH-1:0]  w_data;
   logic [c_nch-1:0]             w_acc;
   logic                         w_accept;

   assign w_rdy = {r3, r2, r1, r0};

   // Readiness looks only at the selected channel, so a stalled channel
   // never blocks words headed elsewhere.
   assign in_ready = rst_n & (~w_full[s] | w_rdy[s]);
   assign w_accept = in_valid & in_ready;

   generate
      for (genvar i = 0; i < c_nch; i++) begin : g_ch
         logic             r_full;
         logic [WIDTH-1:0] r_data;

         assign w_acc[i] = w_accept & (s == 2'(i));

         // An accept wins over a drain on the same edge, keeping full set.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_full <= 1'b0;
               r_data <= '0;
            end else if (w_acc[i]) begin
               r_full <= 1'b1;
               r_data <= d;
            end else if (r_full && w_rdy[i]) begin
               r_full <= 1'b0;
            end
         end

         assign w_full[i] = r_full;
         assign w_data[i] = r_data;
      end
   endgenerate

   assign y0 = w_data[0];
   assign y1 = w_data[1];
   assign y2 = w_data[2];
   assign y3 = w_data[3];
   assign v0 = w_full[0];
   assign v1 = w_full[1];
   assign v2 = w_full[2];
   assign v3 = w_full[3];

`ifdef DEMUX4_COUNT_EN
   logic [c_nch-1:0][7:0] w_cnt;

   generate
      for (genvar j = 0; j < c_nch; j++) begin : g_cnt
         logic [7:0] r_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cnt <= 8'd0;
            end else if (w_acc[j]) begin
               r_cnt <= r_cnt + 8'd1;
            end
         end

         assign w_cnt[j] = r_cnt;
      end
   endgenerate

   assign cnt0 = w_cnt[0];
   assign cnt1 = w_cnt[1];
   assign cnt2 = w_cnt[2];
   assign cnt3 = w_cnt[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux4_router.sv
// ============================================================================
// Module   : tb_demux4_router
// Purpose  : directed self-checking bench for demux4_router (both builds).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux4_router;

   logic       clk;
   logic       rst_n;
   logic [3:0] d;
   logic [1:0] s;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] y0, y1, y2, y3;
   logic       v0, v1, v2, v3;
   logic       r0, r1, r2, r3;
`ifdef DEMUX4_COUNT_EN
   logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

   int nvec = 0;
   int nerr = 0;

   demux4_router #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .d        (d),
      .s        (s),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y0       (y0),
      .y1       (y1),
      .y2       (y2),
      .y3       (y3),
      .v0       (v0),
      .v1       (v1),
      .v2       (v2),
      .v3       (v3),
      .r0       (r0),
      .r1       (r1),
      .r2       (r2),
      .r3       (r3)
`ifdef DEMUX4_COUNT_EN
      ,
      .cnt0     (cnt0),
      .cnt1     (cnt1),
      .cnt2     (cnt2),
      .cnt3     (cnt3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_counts(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
`ifdef DEMUX4_COUNT_EN
      chk({tag, "_cnt"}, {cnt3, cnt2, cnt1, cnt0}, {e3, e2, e1, e0});
`else
      if (tag.len() == 0) $display("empty tag");
`endif
   endtask

   initial begin
      // reset held with a pending word
      rst_n = 1'b0; in_valid = 1'b1; s = 2'd2; d = 4'd6;
      {r3, r2, r1, r0} = 4'b1111;
      #2;
      chk("rst_ready", in_ready, 0);
      chk("rst_v", {v3, v2, v1, v0}, 0);
      chk("rst_y", {y3, y2, y1, y0}, 0);
      chk_counts("rst", 0, 0, 0, 0);
      tick();
      chk("rst_hold_v", {v3, v2, v1, v0}, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", in_ready, 1);
      tick();
      chk("rel_v", {v3, v2, v1, v0}, 4'b0100);
      chk("rel_y2", y2, 6);

      // sweep, all consumers ready
      s = 2'd0; d = 4'd2; #1; chk("sw0_ready", in_ready, 1);
      tick(); chk("sw0_v", {v3, v2, v1, v0}, 4'b0001); chk("sw0_y", y0, 2);
      s = 2'd1; d = 4'd4; #1; chk("sw1_ready", in_ready, 1);
      tick(); chk("sw1_v", {v3, v2, v1, v0}, 4'b0010); chk("sw1_y", y1, 4);
      s = 2'd2; d = 4'd6; #1; chk("sw2_ready", in_ready, 1);
      tick(); chk("sw2_v", {v3, v2, v1, v0}, 4'b0100); chk("sw2_y", y2, 6);
      s = 2'd3; d = 4'd9; #1; chk("sw3_ready", in_ready, 1);
      tick(); chk("sw3_v", {v3, v2, v1, v0}, 4'b1000); chk("sw3_y", y3, 9);
      in_valid = 1'b0;
      tick(); chk("sw_idle_v", {v3, v2, v1, v0}, 0); chk("sw_hold_y3", y3, 9);
      chk_counts("sweep", 1, 1, 2, 1);

      // back-pressure on channel 1
      r1 = 1'b0; in_valid = 1'b1; s = 2'd1; d = 4'd4;
      #1; chk("bp_ready0", in_ready, 1);
      tick(); chk("bp_v1a", v1, 1); chk("bp_y1a", y1, 4);
      d = 4'd7; #1; chk("bp_stall", in_ready, 0);
      tick(); chk("bp_y1_held", y1, 4); chk("bp_v1_held", v1, 1);
      s = 2'd3; d = 4'd9; #1; chk("bp_other_ready", in_ready, 1);
      tick(); chk("bp_v3", v3, 1); chk("bp_y3", y3, 9); chk("bp_y1_still", y1, 4);
      s = 2'd1; d = 4'd7; r1 = 1'b1; #1; chk("bp_release_ready", in_ready, 1);
      tick(); chk("bp_y1b", y1, 7); chk("bp_v", {v3, v2, v1, v0}, 4'b0010);
      in_valid = 1'b0;
      tick(); chk("bp_drain_v", {v3, v2, v1, v0}, 0); chk("bp_y1_keep", y1, 7);
      chk_counts("bp", 1, 3, 2, 2);

      // full throughput on channel 0
      in_valid = 1'b1; s = 2'd0;
      for (int k = 2; k <= 5; k++) begin
         d = 4'(k);
         tick();
         chk("tp_v0", v0, 1);
         chk("tp_y0", y0, 32'(k));
      end
      in_valid = 1'b0;
      tick(); chk("tp_drain_v0", v0, 0);
      chk_counts("tp", 5, 3, 2, 2);

      // asynchronous reset between edges
      r0 = 1'b0; r2 = 1'b0; in_valid = 1'b1;
      s = 2'd0; d = 4'hA; tick();
      s = 2'd2; d = 4'hC; tick();
      in_valid = 1'b0;
      chk("ar_pre_v", {v3, v2, v1, v0}, 4'b0101);
      chk("ar_pre_y", {y2, y0}, 8'hCA);
      #2; rst_n = 1'b0; #1;
      chk("ar_v", {v3, v2, v1, v0}, 0);
      chk("ar_y", {y3, y2, y1, y0}, 0);
      chk("ar_ready", in_ready, 0);
      chk_counts("ar", 0, 0, 0, 0);
      #1; rst_n = 1'b1;
      tick(); chk("ar_after_v", {v3, v2, v1, v0}, 0);

      // 257 accepts to channel 3: counter wraps to 1
      {r3, r2, r1, r0} = 4'b1111; in_valid = 1'b1; s = 2'd3;
      for (int k = 0; k < 257; k++) begin
         d = 4'(k);
         tick();
      end
      in_valid = 1'b0;
      chk("wrap_y3", y3, 0);
      chk("wrap_v3", v3, 1);
      chk_counts("wrap", 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
